// File: rtl/temporal_pkg.sv
// Shared types and constants for the temporal edge encoder.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package temporal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SET     = 2'd1,
        ST_RUN     = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    // Lane values need one extra bit above the window index so that
    // GAMMA_CYCLE_WIDTH and larger can express "never fires".
    function automatic int val_width(input int gamma_cycle_width);
        return $clog2(gamma_cycle_width) + 1;
    endfunction

    // Resting level of every edge line; the active level is its inverse.
`ifdef FALLING_EDGE_EN
    localparam logic INACTIVE_LVL = 1'b1;
`else
    localparam logic INACTIVE_LVL = 1'b0;
`endif

endpackage

// File: rtl/edge_lane.sv
// One temporal lane: goes active once the window index reaches its value, then holds.
// Latency: registered; count/run/clear describe the cycle the output will show.
// Backpressure: none, driven entirely by the encoder sequencer.
module edge_lane
    import temporal_pkg::*;
#(
    parameter int VAL_W = 5,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count,
    input  logic [VAL_W-1:0] value,
    input  logic             run,
    input  logic             clear,
    output logic             edge_out
);

    // Sticky compare: once active the line stays active until cleared, so the edge is monotone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_out <= INACTIVE_LVL;
        end else if (clear) begin
            edge_out <= INACTIVE_LVL;
        end else if (run && (CNT_W'(value) <= count)) begin
            edge_out <= ~INACTIVE_LVL;
        end
    end

endmodule

// File: rtl/temporal_edge_encoder.sv
// Encodes a vector of lane values as edge times within a gamma-cycle window (macro FALLING_EDGE_EN selects falling edges).
// Latency: accept -> SET 1 cycle -> RUN GAMMA_CYCLE_WIDTH cycles -> RECOVER PULSE_WIDTH cycles -> IDLE.
// Backpressure: in_ready is high only in IDLE; in_valid outside IDLE is ignored.
module temporal_edge_encoder
    import temporal_pkg::*;
#(
    parameter int NUM_LANES         = 4,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    localparam int VAL_W            = val_width(GAMMA_CYCLE_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_LANES*VAL_W-1:0] in_value,
    output logic                       set,
    output logic [NUM_LANES-1:0]       edge_out,
    output logic                       gamma_start,
    output logic                       busy
);

    // One counter serves both the RUN index and the RECOVER length.
    localparam int MAX_LEN = (GAMMA_CYCLE_WIDTH > PULSE_WIDTH) ? GAMMA_CYCLE_WIDTH : PULSE_WIDTH;
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    state_t                     state_q;
    state_t                     state_d;
    logic [CNT_W-1:0]           cnt_q;
    logic [CNT_W-1:0]           cnt_d;
    logic [NUM_LANES*VAL_W-1:0] lanes_q;
    logic                       accept;

    // Next-state and counter sequencing for the gamma cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = ST_SET;
                end
            end
            ST_SET: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            ST_RUN: begin
                if (cnt_q == CNT_W'(GAMMA_CYCLE_WIDTH - 1)) begin
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                if (cnt_q == CNT_W'(PULSE_WIDTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, captured lane values, and outputs registered from the next state
    // so that each strobe lines up with the state it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lanes_q     <= '0;
            set         <= 1'b0;
            gamma_start <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (accept) begin
                lanes_q <= in_value;
            end
            set         <= (state_d == ST_SET);
            gamma_start <= (state_q == ST_SET) && (state_d == ST_RUN);
            in_ready    <= (state_d == ST_IDLE);
        end
    end

    assign busy = (state_q != ST_IDLE);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        edge_lane #(
            .VAL_W (VAL_W),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .count    (cnt_d),
            .value    (lanes_q[i*VAL_W +: VAL_W]),
            .run      (state_d == ST_RUN),
            .clear    (state_d != ST_RUN),
            .edge_out (edge_out[i])
        );
    end

endmodule

// File: doc/temporal_edge_encoder.md
TEMPORAL_EDGE_ENCODER -- requirements
Module: temporal_edge_encoder

Interface
REQ-001 Parameter NUM_LANES, default 4: number of independent temporal output lanes.
REQ-002 Parameter GAMMA_CYCLE_WIDTH, default 16: clock cycles per gamma-cycle RUN window.
REQ-003 Parameter PULSE_WIDTH, default 8: recovery cycles between gamma cycles, with all lanes inactive.
REQ-004 Derived constant VAL_W = $clog2(GAMMA_CYCLE_WIDTH)+1: width of each lane value.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  value vector offered.
REQ-008 in_ready  output  1  encoder can accept a vector this cycle.
REQ-009 in_value  input  NUM_LANES*VAL_W  packed lane values, lane 0 in LSBs.
REQ-010 set  output  1  set pulse to downstream less_than SR latches.
REQ-011 edge_out  output  NUM_LANES  temporal edge lines to downstream comparators.
REQ-012 gamma_start  output  1  one-cycle strobe in the first RUN cycle.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 States: IDLE, SET, RUN, RECOVER; held in a registered enum.
REQ-015 IDLE: in_ready=1; in_valid&&in_ready captures in_value into a lane register and moves to SET next cycle.
REQ-016 in_ready SHALL be 0 in SET, RUN and RECOVER; in_valid there is ignored and nothing is captured.
REQ-017 SET lasts exactly 1 cycle with set=1 and all lanes inactive; set=0 in every other state.
REQ-018 RUN lasts exactly GAMMA_CYCLE_WIDTH cycles, indexed k=0..GAMMA_CYCLE_WIDTH-1 by a registered counter.
REQ-019 In RUN cycle k, edge_out[i] is active iff value_i <= k; once active it stays active until RUN ends (monotone edge).
REQ-020 value_i >= GAMMA_CYCLE_WIDTH encodes infinity: lane i never goes active in that gamma cycle.
REQ-021 gamma_start=1 only in RUN cycle k=0.
REQ-022 RECOVER lasts exactly PULSE_WIDTH cycles with all lanes inactive, then the block returns to IDLE.
REQ-023 Accept-to-accept interval SHALL be 1+GAMMA_CYCLE_WIDTH+PULSE_WIDTH+1 cycles minimum (back-to-back in_valid).
REQ-024 Value 0 goes active in the first RUN cycle, the same cycle as gamma_start.
REQ-025 Value GAMMA_CYCLE_WIDTH-1 goes active only in the last RUN cycle.
REQ-026 set, edge_out, gamma_start and in_ready SHALL be registered outputs, glitch-free for the downstream latches.

Reset
REQ-027 rst asserted at any time, including mid-RUN, SHALL force the following immediately: state IDLE, counter 0, lane register 0, set=0, gamma_start=0, busy=0, edge_out all inactive.
REQ-028 in_ready SHALL be 0 while rst is high and 1 in the first cycle after release.

Configuration
REQ-029 Macro FALLING_EDGE_EN undefined: inactive level 0, active level 1 (rising-transition encoding); edge_out resets to all 0.
REQ-030 FALLING_EDGE_EN defined: inactive level 1, active level 0 (falling-transition encoding); edge_out resets to all 1; all timing is unchanged.

Structure
REQ-031 The package temporal_pkg SHALL hold the state enum typedef, the VAL_W computation function, and the INACTIVE_LVL constant selected by FALLING_EDGE_EN.
REQ-032 There SHALL be one sub-module, edge_lane, instantiated NUM_LANES times: it holds the compare-and-hold for one lane, taking the counter, the lane value, and run/clear controls.

Verification
REQ-033 GAMMA=16, PULSE=8, values {0,5,15,16} -> set high 1 cycle; lane0 active at k=0, lane1 at k=5, lane2 at k=15; lane3 never active; all lanes inactive in RECOVER.
REQ-034 in_valid held high with two vectors -> second accepted exactly 26 cycles after the first; in_ready=0 throughout.
REQ-035 rst pulsed at RUN k=7 with lane1 already active -> all lanes inactive and state IDLE immediately; in_ready=1 after release; no residual edges.
REQ-036 FALLING_EDGE_EN build, values {3,3,3,3} -> all lines 1 from reset until RUN k=3, then 0 through RUN k=15, then 1 in RECOVER.
REQ-037 in_valid pulsed during SET/RUN/RECOVER with a different vector -> ignored; the active gamma cycle edges match the originally captured vector.
